// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) receive-path definitions: widths, syndrome positions and
// the single-bit data correction helper used by the packer.
package ham_pkg;

   localparam int NIB_W = 4;
   localparam int CW_W  = 7;
   localparam int SYN_W = 3;

   // Syndrome values that point at a data bit; the remaining nonzero ones are parity bits
   localparam logic [SYN_W-1:0] POS_D0 = 3'd3;
   localparam logic [SYN_W-1:0] POS_D1 = 3'd5;
   localparam logic [SYN_W-1:0] POS_D2 = 3'd6;
   localparam logic [SYN_W-1:0] POS_D3 = 3'd7;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_t;

   function automatic logic [NIB_W-1:0] ham_correct(input logic [NIB_W-1:0] data,
                                                    input logic [SYN_W-1:0] syn);
      logic [NIB_W-1:0] fixed;
      fixed = data;
      case (syn)
         POS_D0:  fixed[0] = ~data[0];
         POS_D1:  fixed[1] = ~data[1];
         POS_D2:  fixed[2] = ~data[2];
         POS_D3:  fixed[3] = ~data[3];
         default: fixed = data;
      endcase
      return fixed;
   endfunction

   function automatic logic is_data_pos(input logic [SYN_W-1:0] syn);
      return (syn == POS_D0) || (syn == POS_D1) || (syn == POS_D2) || (syn == POS_D3);
   endfunction

   function automatic logic is_par_pos(input logic [SYN_W-1:0] syn);
      return (syn == 3'd1) || (syn == 3'd2) || (syn == 3'd4);
   endfunction

endpackage

// File: rtl/ham_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module ham_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != '1)) begin
         cnt_reg <= cnt_reg + ONE;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/ham_rx_packer.sv
// Corrects decoded Hamming nibbles, packs pairs into bytes (low nibble first) on a
// valid/ready stream, and keeps saturating data/parity error statistics.
module ham_rx_packer
   import ham_pkg::*;
#(
   parameter int               CNT_W      = 16,
   parameter logic [NIB_W-1:0] PAD_NIBBLE = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NIB_W-1:0] in_data,
   input  logic [SYN_W-1:0] in_pos_error,
   input  logic             in_error,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic             out_pad,
   output logic [CNT_W-1:0] data_err_cnt,
   output logic [CNT_W-1:0] par_err_cnt,
   input  logic             cnt_clr
);

   pack_state_t      state_reg, state_next;
   logic [NIB_W-1:0] lo_reg, lo_next;
   logic             pend_reg, pend_next;
   logic             out_valid_reg;
   logic [7:0]       out_byte_reg;
   logic             out_pad_reg;

   logic             slot_free;
   logic             accept;
   logic             flush_req;
   logic [NIB_W-1:0] corr;
   logic             load;
   logic [7:0]       load_byte;
   logic             load_pad;

   assign corr      = ham_correct(in_data, in_pos_error);
   assign slot_free = ~out_valid_reg | out_ready;
   assign in_ready  = (state_reg == ST_EMPTY) | slot_free;
   assign accept    = in_valid & in_ready;
   assign flush_req = flush | pend_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_EMPTY;
         lo_reg    <= '0;
         pend_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         lo_reg    <= lo_next;
         pend_reg  <= pend_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      lo_next    = lo_reg;
      pend_next  = pend_reg;
      load       = 1'b0;
      load_byte  = out_byte_reg;
      load_pad   = 1'b0;
      case (state_reg)
         ST_EMPTY: begin
            // Nothing to pad, so any flush (fresh or held) is dropped here
            pend_next = 1'b0;
            if (accept) begin
               lo_next    = corr;
               state_next = ST_HALF;
            end
         end
         ST_HALF: begin
            if (accept) begin
               load       = 1'b1;
               load_byte  = {corr, lo_reg};
               pend_next  = 1'b0;
               state_next = ST_EMPTY;
            end else if (flush_req) begin
               if (slot_free) begin
                  load       = 1'b1;
                  load_byte  = {PAD_NIBBLE, lo_reg};
                  load_pad   = 1'b1;
                  pend_next  = 1'b0;
                  state_next = ST_EMPTY;
               end else begin
                  pend_next = 1'b1;
               end
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Output slot: reloading in the same cycle as a handshake keeps full throughput
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_byte_reg  <= '0;
         out_pad_reg   <= 1'b0;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_byte_reg  <= load_byte;
         out_pad_reg   <= load_pad;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_byte  = out_byte_reg;
   assign out_pad   = out_pad_reg;

   // The syndrome decides the class; a nonzero syndrome counts even if in_error is low
   logic             err_any;
   logic [1:0]       inc_vec;
   logic [CNT_W-1:0] cnt_vec [2];

   assign err_any    = in_error | (|in_pos_error);
   assign inc_vec[0] = accept & err_any & is_data_pos(in_pos_error);
   assign inc_vec[1] = accept & err_any & is_par_pos(in_pos_error);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         ham_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc_vec[gi]),
            .clr (cnt_clr),
            .cnt (cnt_vec[gi])
         );
      end
   endgenerate

   assign data_err_cnt = cnt_vec[0];
   assign par_err_cnt  = cnt_vec[1];

endmodule
